// File: rtl/txn_sequencer.sv
// Control FSM that sequences one coin transfer: load amount/key, verify, transfer, write back.
// Optional macro TXN_KEY_RETRY_EN: a VER_KEY timeout returns to WAIT_KEY up to 2 times.
module txn_sequencer #(
    parameter int ADDR_W      = 2,
    parameter int TIMEOUT     = 15,
    parameter int P1_BAL_ADDR = 0,
    parameter int P2_BAL_ADDR = 1,
    parameter int P1_KEY_ADDR = 2,
    parameter int P2_KEY_ADDR = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              go,
    input  logic              sender,
    input  logic              enter,
    input  logic              done_step,
    input  logic [10:0]       p1_amount_out,
    input  logic [10:0]       p2_amount_out,
    output logic              load_amount,
    output logic              load_key,
    output logic [2:0]        process,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [10:0]       mem_data,
    output logic              busy,
    output logic              txn_ok,
    output logic              txn_fail
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_AMT, S_VER_AMT, S_WAIT_KEY, S_VER_KEY,
        S_XFER_P1, S_XFER_P2, S_WR_P1, S_WR_P2, S_OK, S_FAIL
    } state_t;

    localparam logic [3:0]        TIMEOUT_CNT = 4'(TIMEOUT);
    localparam logic [ADDR_W-1:0] A_P1_BAL    = ADDR_W'(P1_BAL_ADDR);
    localparam logic [ADDR_W-1:0] A_P2_BAL    = ADDR_W'(P2_BAL_ADDR);
    localparam logic [ADDR_W-1:0] A_P1_KEY    = ADDR_W'(P1_KEY_ADDR);
    localparam logic [ADDR_W-1:0] A_P2_KEY    = ADDR_W'(P2_KEY_ADDR);

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        sender_reg, sender_next;
    logic        settled, timed_out;

    logic              load_amount_next, load_key_next, mem_wren_next;
    logic              busy_next, txn_ok_next, txn_fail_next;
    logic [2:0]        process_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [10:0]       mem_data_next;

`ifdef TXN_KEY_RETRY_EN
    logic [1:0] retry_cnt_reg, retry_cnt_next;
`endif

    // Count 0 is the cycle the memory address was just changed; read data is not valid yet.
    assign settled   = (wait_cnt_reg != 4'd0);
    assign timed_out = (wait_cnt_reg == TIMEOUT_CNT);

    always_comb begin
        state_next  = state_reg;
        sender_next = sender_reg;
`ifdef TXN_KEY_RETRY_EN
        retry_cnt_next = (state_reg == S_IDLE) ? 2'd0 : retry_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (go) begin
                    sender_next = sender;
                    state_next  = S_WAIT_AMT;
                end
            end
            S_WAIT_AMT: if (enter) state_next = S_VER_AMT;
            S_VER_AMT: begin
                if (settled && done_step) state_next = S_WAIT_KEY;
                else if (timed_out)       state_next = S_FAIL;
            end
            S_WAIT_KEY: if (enter) state_next = S_VER_KEY;
            S_VER_KEY: begin
                if (settled && done_step) begin
                    state_next = S_XFER_P1;
                end else if (timed_out) begin
`ifdef TXN_KEY_RETRY_EN
                    if (retry_cnt_reg < 2'd2) begin
                        retry_cnt_next = retry_cnt_reg + 2'd1;
                        state_next     = S_WAIT_KEY;
                    end else begin
                        state_next = S_FAIL;
                    end
`else
                    state_next = S_FAIL;
`endif
                end
            end
            S_XFER_P1: state_next = S_XFER_P2;
            S_XFER_P2: begin
                if (done_step)      state_next = S_WR_P1;
                else if (timed_out) state_next = S_FAIL;
            end
            S_WR_P1: state_next = S_WR_P2;
            S_WR_P2: state_next = S_OK;
            S_OK:    state_next = S_IDLE;
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (state_next != state_reg)   wait_cnt_next = 4'd0;
        else if (wait_cnt_reg == 4'hF) wait_cnt_next = 4'hF;
        else                           wait_cnt_next = wait_cnt_reg + 4'd1;
    end

    // Outputs are decoded from the next state and registered so they line up with state_reg.
    always_comb begin
        load_amount_next = (state_reg == S_WAIT_AMT) && (state_next == S_VER_AMT);
        load_key_next    = (state_reg == S_WAIT_KEY) && (state_next == S_VER_KEY);
        process_next     = 3'b000;
        mem_addr_next    = '0;
        mem_wren_next    = 1'b0;
        mem_data_next    = 11'd0;
        busy_next        = (state_next != S_IDLE);
        txn_ok_next      = (state_next == S_OK);
        txn_fail_next    = (state_next == S_FAIL);
        case (state_next)
            S_VER_AMT: begin
                process_next  = 3'b001;
                mem_addr_next = sender_next ? A_P2_BAL : A_P1_BAL;
            end
            S_VER_KEY: begin
                process_next  = 3'b010;
                mem_addr_next = sender_next ? A_P2_KEY : A_P1_KEY;
            end
            S_XFER_P1: begin
                process_next  = 3'b100;
                mem_addr_next = A_P1_BAL;
            end
            S_XFER_P2: begin
                process_next  = 3'b100;
                mem_addr_next = A_P2_BAL;
            end
            S_WR_P1: begin
                process_next  = 3'b100;
                mem_addr_next = A_P1_BAL;
                mem_wren_next = 1'b1;
                mem_data_next = p1_amount_out;
            end
            S_WR_P2: begin
                process_next  = 3'b100;
                mem_addr_next = A_P2_BAL;
                mem_wren_next = 1'b1;
                mem_data_next = p2_amount_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            sender_reg   <= 1'b0;
            load_amount  <= 1'b0;
            load_key     <= 1'b0;
            process      <= 3'b000;
            mem_addr     <= '0;
            mem_wren     <= 1'b0;
            mem_data     <= 11'd0;
            busy         <= 1'b0;
            txn_ok       <= 1'b0;
            txn_fail     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            sender_reg   <= sender_next;
            load_amount  <= load_amount_next;
            load_key     <= load_key_next;
            process      <= process_next;
            mem_addr     <= mem_addr_next;
            mem_wren     <= mem_wren_next;
            mem_data     <= mem_data_next;
            busy         <= busy_next;
            txn_ok       <= txn_ok_next;
            txn_fail     <= txn_fail_next;
        end
    end

`ifdef TXN_KEY_RETRY_EN
    always_ff @(posedge clock) begin
        if (!resetn) retry_cnt_reg <= 2'd0;
        else         retry_cnt_reg <= retry_cnt_next;
    end
`endif

endmodule

// File: tb/tb_txn_sequencer.sv
// Self-checking bench for txn_sequencer; memory writes are checked against a scoreboard queue.
module tb_txn_sequencer;

    localparam int TIMEOUT = 15;

    logic        clock = 1'b0;
    logic        resetn, go, sender, enter, done_step;
    logic [10:0] p1_amount_out, p2_amount_out;
    logic        load_amount, load_key, mem_wren, busy, txn_ok, txn_fail;
    logic [2:0]  process;
    logic [1:0]  mem_addr;
    logic [10:0] mem_data;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];

    txn_sequencer #(.ADDR_W(2), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetn(resetn), .go(go), .sender(sender), .enter(enter),
        .done_step(done_step), .p1_amount_out(p1_amount_out), .p2_amount_out(p2_amount_out),
        .load_amount(load_amount), .load_key(load_key), .process(process),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_data(mem_data),
        .busy(busy), .txn_ok(txn_ok), .txn_fail(txn_fail)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wren) obs_q.push_back({mem_addr, mem_data});
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0; go = 1'b0; sender = 1'b0; enter = 1'b0; done_step = 1'b0;
        p1_amount_out = 11'd0; p2_amount_out = 11'd0;
        step(); step();
        checks++; if (process !== 3'b000) begin errors++; $display("FAIL reset_process got=%b want=000", process); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b want=0", mem_wren); end
        checks++; if ({load_amount, load_key, txn_ok, txn_fail} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses got=%b want=0000", {load_amount, load_key, txn_ok, txn_fail}); end
        checks++; if (mem_addr !== 2'd0 || mem_data !== 11'd0) begin
            errors++; $display("FAIL reset_mem got=%0d/%h want=0/000", mem_addr, mem_data); end
        resetn = 1'b1;
        step();
        $display("txn reset: checked idle outputs");
    endtask

    // Full successful transfer; done_step arrives on the 2nd cycle of each waiting step.
    task automatic test_transfer(input logic s, input logic [10:0] v1, input logic [10:0] v2);
        logic [1:0]  bal_a, key_a;
        logic [12:0] e, o;
        bal_a = s ? 2'd1 : 2'd0;
        key_a = s ? 2'd3 : 2'd2;
        exp_q.push_back({2'd0, v1});
        exp_q.push_back({2'd1, v2});
        p1_amount_out = v1; p2_amount_out = v2;
        sender = s; go = 1'b1;
        step(); go = 1'b0;
        checks++; if (busy !== 1'b1 || process !== 3'b000) begin
            errors++; $display("FAIL xfer_wait_amt got busy=%b proc=%b want busy=1 proc=000", busy, process); end
        enter = 1'b1; step(); enter = 1'b0;
        checks++; if (load_amount !== 1'b1 || process !== 3'b001 || mem_addr !== bal_a) begin
            errors++; $display("FAIL xfer_ver_amt got ld=%b proc=%b addr=%0d want 1/001/%0d", load_amount, process, mem_addr, bal_a); end
        step();
        checks++; if (load_amount !== 1'b0) begin errors++; $display("FAIL xfer_ld_amt_pulse got=%b want=0", load_amount); end
        done_step = 1'b1; step(); done_step = 1'b0;
        checks++; if (process !== 3'b000 || load_key !== 1'b0) begin
            errors++; $display("FAIL xfer_wait_key got proc=%b ldk=%b want 000/0", process, load_key); end
        enter = 1'b1; step(); enter = 1'b0;
        checks++; if (load_key !== 1'b1 || process !== 3'b010 || mem_addr !== key_a) begin
            errors++; $display("FAIL xfer_ver_key got ld=%b proc=%b addr=%0d want 1/010/%0d", load_key, process, mem_addr, key_a); end
        step(); done_step = 1'b1; step(); done_step = 1'b0;
        checks++; if (process !== 3'b100 || mem_addr !== 2'd0 || load_key !== 1'b0) begin
            errors++; $display("FAIL xfer_p1 got proc=%b addr=%0d ldk=%b want 100/0/0", process, mem_addr, load_key); end
        step();
        checks++; if (process !== 3'b100 || mem_addr !== 2'd1 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL xfer_p2 got proc=%b addr=%0d wren=%b want 100/1/0", process, mem_addr, mem_wren); end
        step(); done_step = 1'b1; step(); done_step = 1'b0;
        step(); step();
        checks++; if (txn_ok !== 1'b1 || txn_fail !== 1'b0 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL xfer_ok got ok=%b fail=%b wren=%b want 1/0/0", txn_ok, txn_fail, mem_wren); end
        step();
        checks++; if (busy !== 1'b0 || txn_ok !== 1'b0) begin
            errors++; $display("FAIL xfer_idle got busy=%b ok=%b want 0/0", busy, txn_ok); end
        checks++; if (obs_q.size() != 2) begin
            errors++; $display("FAIL xfer_wr_count got=%0d want=2", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'h1FFF;
            checks++; if (o !== e) begin
                errors++; $display("FAIL xfer_wr got addr=%0d data=%h want addr=%0d data=%h", o[12:11], o[10:0], e[12:11], e[10:0]); end
        end
        obs_q.delete();
        $display("txn transfer sender=%0d p1=%h p2=%h done", s, v1, v2);
    endtask

    task automatic test_settle();
        sender = 1'b0; go = 1'b1; step(); go = 1'b0;
        enter = 1'b1; done_step = 1'b1; step(); enter = 1'b0;
        step();
        checks++; if (process !== 3'b001) begin errors++; $display("FAIL settle_ignored got proc=%b want=001", process); end
        step(); done_step = 1'b0;
        checks++; if (process !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("FAIL settle_accept got proc=%b busy=%b want 000/1", process, busy); end
        resetn = 1'b0; step(); resetn = 1'b1; step();
        $display("txn settle: done_step ignored in first VER_AMT cycle");
    endtask

    task automatic test_amt_timeout();
        int  n;
        logic wr_seen;
        n = 0; wr_seen = 1'b0;
        sender = 1'b0; go = 1'b1; step(); go = 1'b0;
        enter = 1'b1; step(); enter = 1'b0;
        while (txn_fail !== 1'b1 && n < 40) begin
            step(); n++;
            if (mem_wren) wr_seen = 1'b1;
        end
        checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL amt_timeout_cycles got=%0d want=%0d", n, TIMEOUT + 1); end
        checks++; if (wr_seen !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL amt_timeout_wren got=%b/%0d want=0/0", wr_seen, obs_q.size()); end
        step();
        checks++; if (busy !== 1'b0 || txn_fail !== 1'b0) begin
            errors++; $display("FAIL amt_timeout_idle got busy=%b fail=%b want 0/0", busy, txn_fail); end
        obs_q.delete();
        $display("txn amount timeout after %0d cycles", n);
    endtask

    task automatic test_key_timeout();
        int n;
        int rounds;
`ifdef TXN_KEY_RETRY_EN
        rounds = 3;
`else
        rounds = 1;
`endif
        sender = 1'b1; go = 1'b1; step(); go = 1'b0;
        enter = 1'b1; step(); enter = 1'b0;
        step(); done_step = 1'b1; step(); done_step = 1'b0;
        enter = 1'b1; step(); enter = 1'b0;
        for (int r = 0; r < rounds; r++) begin
            n = 0;
            while (process === 3'b010 && txn_fail !== 1'b1 && n < 40) begin
                step(); n++;
            end
            checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL key_timeout_cycles round=%0d got=%0d want=%0d", r, n, TIMEOUT + 1); end
            if (r == rounds - 1) begin
                checks++; if (txn_fail !== 1'b1) begin errors++; $display("FAIL key_timeout_fail round=%0d got=%b want=1", r, txn_fail); end
            end else begin
                checks++; if (txn_fail !== 1'b0 || busy !== 1'b1 || process !== 3'b000) begin
                    errors++; $display("FAIL key_retry round=%0d got fail=%b busy=%b proc=%b want 0/1/000", r, txn_fail, busy, process); end
                enter = 1'b1; step(); enter = 1'b0;
            end
        end
        step();
        checks++; if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL key_timeout_idle got busy=%b writes=%0d want 0/0", busy, obs_q.size()); end
        obs_q.delete();
        $display("txn key timeout with %0d rounds", rounds);
    endtask

    task automatic test_reset_mid();
        sender = 1'b0; go = 1'b1; step(); go = 1'b0;
        enter = 1'b1; step(); enter = 1'b0;
        step(); done_step = 1'b1; step(); done_step = 1'b0;
        enter = 1'b1; step(); enter = 1'b0;
        step();
        resetn = 1'b0; step();
        checks++; if (process !== 3'b000 || busy !== 1'b0 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL mid_reset got proc=%b busy=%b wren=%b want 000/0/0", process, busy, mem_wren); end
        checks++; if ({load_amount, load_key, txn_ok, txn_fail} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset_pulses got=%b want=0000", {load_amount, load_key, txn_ok, txn_fail}); end
        resetn = 1'b1; step(); step();
        checks++; if (busy !== 1'b0 || obs_q.size() != 0 || txn_ok !== 1'b0) begin
            errors++; $display("FAIL mid_reset_after got busy=%b writes=%0d ok=%b want 0/0/0", busy, obs_q.size(), txn_ok); end
        obs_q.delete();
        $display("txn reset mid VER_KEY aborted");
    endtask

    task automatic test_go_enter_idle();
        sender = 1'b0; go = 1'b1; enter = 1'b1; step();
        checks++; if (load_amount !== 1'b0 || process !== 3'b000 || busy !== 1'b1) begin
            errors++; $display("FAIL go_enter got ld=%b proc=%b busy=%b want 0/000/1", load_amount, process, busy); end
        enter = 1'b0; sender = 1'b1; step(); go = 1'b0;
        checks++; if (process !== 3'b000 || load_amount !== 1'b0) begin
            errors++; $display("FAIL go_busy got proc=%b ld=%b want 000/0", process, load_amount); end
        enter = 1'b1; step(); enter = 1'b0;
        checks++; if (process !== 3'b001 || mem_addr !== 2'd0) begin
            errors++; $display("FAIL go_sender_latched got proc=%b addr=%0d want 001/0", process, mem_addr); end
        resetn = 1'b0; step(); resetn = 1'b1; step();
        $display("txn go+enter in idle: enter dropped, go ignored while busy");
    endtask

    task automatic test_back_to_back();
        test_transfer(1'b1, 11'h123, 11'h456);
        test_transfer(1'b0, 11'h7FF, 11'h000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transfer(1'b0, 11'h50A, 11'h614);
        test_settle();
        test_amt_timeout();
        test_key_timeout();
        test_reset_mid();
        test_go_enter_idle();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
